alu_issuer: RTL and testbench

- Sequential front end for the combinational `alu`: it accepts ALU operations on a valid/ready input channel and drives `enable`/`command`/`a`/`b` for exactly one cycle per operation.
- It captures `result`/`overflow` and presents them on a valid/ready response channel.
- It keeps a sticky overflow flag and a completed-operation counter.
- It sits between the instruction/control path and the `alu` instance. It is the initiator side of the ALU operand/result interface.

---
 rtl/alu_issuer.sv | 137 +++++++++++++
 tb/tb_alu_issuer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// -----------------------------------------------------------------------------
// alu_issuer
//
// Purpose:
//   Sequential front end for the combinational alu. It accepts one operation on
//   a valid/ready request channel. For a legal opcode it drives the alu for
//   exactly one cycle. It then captures the alu result and overflow, and
//   presents them on a valid/ready response channel. It also keeps a sticky
//   overflow flag and a counter of completed response handshakes.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_command/in_a/in_b  requested opcode and operands
//   alu_enable/alu_command/alu_a/alu_b
//                         drive the alu; non-zero only while executing
//   alu_overflow/alu_result
//                         combinational alu outputs, captured at end of EXEC
//   out_valid/out_ready   response handshake
//   out_command/out_result/out_overflow/out_error
//                         captured response; out_error flags opcode 0xA-0xF
//   clear_sticky          clears sticky_overflow (a same-edge set wins)
//   sticky_overflow       set by any captured alu overflow
//   op_count              completed response handshakes, wraps silently
// -----------------------------------------------------------------------------
module alu_issuer #(
  parameter int SIZE      = 4,
  parameter int FULL_SIZE = 2 * SIZE,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_command,
  input  logic [SIZE-1:0]      in_a,
  input  logic [SIZE-1:0]      in_b,
  output logic                 alu_enable,
  output logic [3:0]           alu_command,
  output logic [SIZE-1:0]      alu_a,
  output logic [SIZE-1:0]      alu_b,
  input  logic                 alu_overflow,
  input  logic [FULL_SIZE-1:0] alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_command,
  output logic [FULL_SIZE-1:0] out_result,
  output logic                 out_overflow,
  output logic                 out_error,
  input  logic                 clear_sticky,
  output logic                 sticky_overflow,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [3:0]      cmd_q;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic            in_legal;

  // Opcodes 0x0-0x9 exist in the alu; the rest bypass it as errors.
  assign in_legal = (in_command <= 4'd9);

  // All handshake and alu-drive outputs decode from the state only, so no
  // input reaches an output combinationally.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == RESP);
  assign alu_enable  = (state == EXEC);
  assign alu_command = (state == EXEC) ? cmd_q : 4'd0;
  assign alu_a       = (state == EXEC) ? a_q   : '0;
  assign alu_b       = (state == EXEC) ? b_q   : '0;

  // Main sequencer: latch request, execute once, hold the response until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_q        <= 4'd0;
      a_q          <= '0;
      b_q          <= '0;
      out_command  <= 4'd0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_error    <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cmd_q <= in_command;
            a_q   <= in_a;
            b_q   <= in_b;
            if (in_legal) begin
              state <= EXEC;
            end else begin
              // Illegal opcodes produce an error response immediately.
              state        <= RESP;
              out_command  <= in_command;
              out_result   <= '0;
              out_overflow <= 1'b0;
              out_error    <= 1'b1;
            end
          end
        end
        EXEC: begin
          out_command  <= cmd_q;
          out_result   <= alu_result;
          out_overflow <= alu_overflow;
          out_error    <= 1'b0;
          state        <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            state    <= IDLE;
            op_count <= op_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a capture with overflow takes priority over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_overflow <= 1'b0;
    end else if ((state == EXEC) && alu_overflow) begin
      sticky_overflow <= 1'b1;
    end else if (clear_sticky) begin
      sticky_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_issuer
//
// Purpose:
//   Directed self-checking bench for alu_issuer. A small behavioural alu model
//   sits on the alu side. A second instance with CNT_W=2 shares the request
//   and response stimulus so that the op_count wrap can be observed.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_alu_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_command;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_ready;
  logic       clear_sticky;

  logic       in_ready, alu_enable, alu_overflow, out_valid, out_overflow, out_error, sticky_overflow;
  logic [3:0] alu_command, alu_a, alu_b, out_command;
  logic [7:0] alu_result, out_result;
  logic [15:0] op_count;

  logic       w_in_ready, w_alu_enable, w_alu_overflow, w_out_valid, w_out_overflow, w_out_error, w_sticky;
  logic [3:0] w_alu_command, w_alu_a, w_alu_b, w_out_command;
  logic [7:0] w_alu_result, w_out_result;
  logic [1:0] w_op_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // Behavioural alu: 0x0 AND, 0x4 add (SIZE-bit result, carry = overflow),
  // 0x8 multiply (overflow when the product exceeds SIZE bits), others {a,b}.
  function automatic logic [8:0] alu_model(input logic en, input logic [3:0] c,
                                           input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    logic [7:0] prod;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {4'd0, a} * {4'd0, b};
    if (!en) return 9'd0;
    case (c)
      4'h0:    return {1'b0, 4'd0, a & b};
      4'h4:    return {sum[4], 4'd0, sum[3:0]};
      4'h8:    return {(prod > 8'd15), prod};
      default: return {1'b0, a, b};
    endcase
  endfunction

  assign {alu_overflow, alu_result}     = alu_model(alu_enable, alu_command, alu_a, alu_b);
  assign {w_alu_overflow, w_alu_result} = alu_model(w_alu_enable, w_alu_command, w_alu_a, w_alu_b);

  alu_issuer #(.SIZE(4), .FULL_SIZE(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_a(in_a), .in_b(in_b),
    .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_overflow(alu_overflow), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_command(out_command),
    .out_result(out_result), .out_overflow(out_overflow), .out_error(out_error),
    .clear_sticky(clear_sticky), .sticky_overflow(sticky_overflow), .op_count(op_count)
  );

  alu_issuer #(.SIZE(4), .FULL_SIZE(8), .CNT_W(2)) u_dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_command(in_command), .in_a(in_a), .in_b(in_b),
    .alu_enable(w_alu_enable), .alu_command(w_alu_command), .alu_a(w_alu_a), .alu_b(w_alu_b),
    .alu_overflow(w_alu_overflow), .alu_result(w_alu_result),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_command(w_out_command),
    .out_result(w_out_result), .out_overflow(w_out_overflow), .out_error(w_out_error),
    .clear_sticky(clear_sticky), .sticky_overflow(w_sticky), .op_count(w_op_count)
  );

  // Advance one rising edge and settle 1ns past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_command = 4'd0; in_a = 4'd0; in_b = 4'd0;
    out_ready = 1'b0; clear_sticky = 1'b0;
    tick(); tick();
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_alu_enable got %b want 0", alu_enable); end
    n_compared++; if (out_result !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_out_result got %h want 00", out_result); end
    n_compared++; if (out_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_error got %b want 0", out_error); end
    n_compared++; if (sticky_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_sticky got %b want 0", sticky_overflow); end
    n_compared++; if (op_count !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_op_count got %0d want 0", op_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_command = 4'h0; in_a = 4'h7; in_b = 4'h3;
    tick();  // request handshake edge
    in_valid = 1'b0;
    n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_alu_enable got %b want 1", alu_enable); end
    n_compared++; if ({alu_a, alu_b} !== 8'h73) begin n_mismatched++; $display("[TB] FAIL basic_alu_ab got %h want 73", {alu_a, alu_b}); end
    n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_in_ready got %b want 0", in_ready); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_early_valid got %b want 0", out_valid); end
    tick();  // EXEC capture edge
    n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_enable_one_cycle got %b want 0", alu_enable); end
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
    n_compared++; if ({out_error, out_overflow, out_result} !== 10'h003) begin n_mismatched++; $display("[TB] FAIL basic_response got %h want 003", {out_error, out_overflow, out_result}); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (op_count !== 16'd1) begin n_mismatched++; $display("[TB] FAIL basic_op_count got %0d want 1", op_count); end
    n_compared++; if ({out_valid, in_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL basic_back_idle got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_command = 4'h8; in_a = 4'h7; in_b = 4'h8;
    tick();
    in_command = 4'h0; in_a = 4'h1; in_b = 4'h1;  // second request held valid
    tick();
    for (int i = 0; i < 5; i++) begin
      n_compared++; if ({out_valid, in_ready} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL bp_valid_ready[%0d] got %b want 10", i, {out_valid, in_ready}); end
      n_compared++; if ({out_overflow, out_result} !== 9'h138) begin n_mismatched++; $display("[TB] FAIL bp_hold[%0d] got %h want 138", i, {out_overflow, out_result}); end
      n_compared++; if (sticky_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_sticky[%0d] got %b want 1", i, sticky_overflow); end
      tick();
    end
    n_compared++; if (out_command !== 4'h8) begin n_mismatched++; $display("[TB] FAIL bp_command got %h want 8", out_command); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if ({out_valid, in_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL bp_release got %b want 01", {out_valid, in_ready}); end
    n_compared++; if (op_count !== 16'd2) begin n_mismatched++; $display("[TB] FAIL bp_op_count got %0d want 2", op_count); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_command = 4'hC; in_a = 4'h5; in_b = 4'h5;
    tick();
    in_valid = 1'b0;
    n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ill_alu_enable got %b want 0", alu_enable); end
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_out_valid got %b want 1", out_valid); end
    n_compared++; if ({out_error, out_overflow, out_result} !== 10'h200) begin n_mismatched++; $display("[TB] FAIL ill_response got %h want 200", {out_error, out_overflow, out_result}); end
    n_compared++; if (out_command !== 4'hC) begin n_mismatched++; $display("[TB] FAIL ill_command got %h want c", out_command); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ill_alu_enable_late got %b want 0", alu_enable); end
    n_compared++; if (op_count !== 16'd3) begin n_mismatched++; $display("[TB] FAIL ill_op_count got %0d want 3", op_count); end
  endtask

  task automatic test_sticky();
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    n_compared++; if (sticky_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sticky_clear0 got %b want 0", sticky_overflow); end
    in_valid = 1'b1; in_command = 4'h4; in_a = 4'hF; in_b = 4'h1;
    tick();
    in_valid = 1'b0;
    tick();
    n_compared++; if ({out_overflow, out_result} !== 9'h100) begin n_mismatched++; $display("[TB] FAIL sticky_add got %h want 100", {out_overflow, out_result}); end
    n_compared++; if (sticky_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sticky_set got %b want 1", sticky_overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    n_compared++; if (sticky_overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sticky_idle_clear got %b want 0", sticky_overflow); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clear_sticky = 1'b1;  // clear coincides with the capture edge
    tick();
    clear_sticky = 1'b0;
    n_compared++; if (sticky_overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sticky_set_wins got %b want 1", sticky_overflow); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (op_count !== 16'd5) begin n_mismatched++; $display("[TB] FAIL sticky_op_count got %0d want 5", op_count); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_command = 4'h0; in_a = 4'h7; in_b = 4'h3;
    tick();  // now in EXEC
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_compared++; if ({alu_enable, out_valid, in_ready} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL rst_exec_ctrl got %b want 001", {alu_enable, out_valid, in_ready}); end
    n_compared++; if ({sticky_overflow, op_count} !== 17'd0) begin n_mismatched++; $display("[TB] FAIL rst_exec_state got %h want 0", {sticky_overflow, op_count}); end
    tick(); tick();
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_exec_no_resp got %b want 0", out_valid); end
    in_valid = 1'b1; in_command = 4'h8; in_a = 4'h7; in_b = 4'h8;
    tick();
    in_valid = 1'b0;
    tick();  // now in RESP
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_compared++; if ({out_valid, in_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rst_resp_ctrl got %b want 01", {out_valid, in_ready}); end
    n_compared++; if ({out_command, out_error, out_overflow, out_result} !== 14'd0) begin n_mismatched++; $display("[TB] FAIL rst_resp_out got %h want 0", {out_command, out_error, out_overflow, out_result}); end
    n_compared++; if ({sticky_overflow, op_count} !== 17'd0) begin n_mismatched++; $display("[TB] FAIL rst_resp_state got %h want 0", {sticky_overflow, op_count}); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    in_valid = 1'b1; in_command = 4'h1; in_a = 4'h2; in_b = 4'h3; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); tick(); tick();
      n_compared++; if (w_op_count !== wrap_exp[k]) begin n_mismatched++; $display("[TB] FAIL wrap_count[%0d] got %0d want %0d", k, w_op_count, wrap_exp[k]); end
      n_compared++; if (op_count !== 16'(k + 1)) begin n_mismatched++; $display("[TB] FAIL b2b_count[%0d] got %0d want %0d", k, op_count, k + 1); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_compared++; if (out_result !== 8'h23) begin n_mismatched++; $display("[TB] FAIL b2b_result got %h want 23", out_result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_sticky();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
